data_memory_controller: RTL and testbench

Sequences one MIPS MEM-stage load or store onto the word-wide data memory. Checks alignment, generates byte enables and store-lane steering, runs a request/acknowledge handshake with a variable-latency memory, and applies a timeout. Load data is returned lane-aligned and zero- or sign-extended. Sits between the pipeline's MEM stage, which stalls on `busy_out`, and the data memory port.

---
 rtl/mem_access_pkg.sv | 19 +
 rtl/load_extender.sv | 21 ++
 rtl/data_memory_controller.sv | 183 ++++++++++++++++++
 tb/tb_data_memory_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access path: transfer sizes,
// completion error codes and the controller state enum.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/load_extender.sv
// Zero/sign extension of a lane-aligned load word to 32 bits.
module load_extender
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    // Pick the low byte/half and fill the upper bits; word and reserved pass through
    always_comb begin
        result = word;
        case (size)
            SIZE_BYTE: result = {{24{sign_ext & word[7]}}, word[7:0]};
            SIZE_HALF: result = {{16{sign_ext & word[15]}}, word[15:0]};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/data_memory_controller.sv
// MEM-stage load/store sequencer: alignment check, byte-enable and lane
// steering, request/ack handshake with a variable-latency memory, timeout.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | waiting for req_in; request fields latched on acceptance
//   ST_ACCESS | mem_req_out high, waiting for mem_ack_in or timeout
//   ST_DONE   | one-cycle done_out pulse with error_out/rdata_out valid
module data_memory_controller
    import mem_access_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_in,
    input  logic              write_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [1:0]        size_in,
    input  logic              signed_in,
    input  logic [31:0]       wdata_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [1:0]        error_out,
    output logic [31:0]       rdata_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [3:0]        mem_be_out,
    output logic [31:0]       mem_wdata_out,
    input  logic              mem_ack_in,
    input  logic [31:0]       mem_rdata_in
);

    // Down-counter is loaded with N-1 so terminal count lands on the Nth ACCESS cycle
    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_t state, next_state;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [15:0]       timer;
    logic [1:0]        err_q;
    logic [31:0]       rdata_q;

    logic [1:0]  req_offset;
    logic        req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        accept;
    logic        ack_hit;
    logic        timer_tc;
    logic [31:0] load_shifted;
    logic [31:0] load_ext;

    assign req_offset = addr_in[1:0];
    assign accept     = (state == ST_IDLE) && req_in;
    assign ack_hit    = (state == ST_ACCESS) && mem_ack_in;
    assign timer_tc   = (timer == 16'd0);

    // Alignment check and byte enables for the incoming request
    always_comb begin
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        case (size_in)
            SIZE_BYTE: begin
                req_misaligned = 1'b0;
                req_be         = 4'b0001 << req_offset;
            end
            SIZE_HALF: begin
                req_misaligned = req_offset[0];
                req_be         = 4'b0011 << req_offset;
            end
            default: begin
                req_misaligned = (req_offset != 2'b00);
                req_be         = 4'b1111;
            end
        endcase
    end

    // Store data steered to its byte lane
    always_comb begin
        req_wdata = wdata_in << {req_offset, 3'b000};
    end

    // Read word shifted down so the addressed lane sits at bit 0
    always_comb begin
        load_shifted = mem_rdata_in >> {addr_q[1:0], 3'b000};
    end

    load_extender u_load_extender (
        .word     (load_shifted),
        .size     (size_q),
        .sign_ext (signed_q),
        .result   (load_ext)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= next_state;
    end

    // Next-state logic; ack takes priority over timer terminal count
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_in) next_state = req_misaligned ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (mem_ack_in || timer_tc) next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state flops
    always_comb begin
        busy_out    = (state != ST_IDLE);
        done_out    = (state == ST_DONE);
        mem_req_out = (state == ST_ACCESS);
        mem_we_out  = (state == ST_ACCESS) && we_q;
    end

    // Latch the request so address, enables and data stay stable through ACCESS
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else if (accept) begin
            we_q     <= write_in;
            addr_q   <= addr_in;
            size_q   <= size_in;
            signed_q <= signed_in;
            wdata_q  <= req_wdata;
            be_q     <= req_be;
        end
    end

    // Timeout down-counter, loaded on acceptance and decremented while waiting
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            timer <= '0;
        end else if (accept) begin
            timer <= TIMER_LOAD;
        end else if ((state == ST_ACCESS) && !timer_tc) begin
            timer <= timer - 16'd1;
        end
    end

    // Completion status and load data; rdata only moves on an acked load
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_q   <= ERR_OK;
            rdata_q <= '0;
        end else if (accept) begin
            err_q <= req_misaligned ? ERR_MISALIGN : ERR_OK;
        end else if (ack_hit) begin
            err_q <= ERR_OK;
            if (!we_q) rdata_q <= load_ext;
        end else if ((state == ST_ACCESS) && timer_tc) begin
            err_q <= ERR_TIMEOUT;
        end
    end

    assign error_out     = err_q;
    assign rdata_out     = rdata_q;
    assign mem_addr_out  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_be_out    = be_q;
    assign mem_wdata_out = wdata_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Self-checking bench for data_memory_controller: directed cases from the
// test plan followed by randomized accesses against a behavioural model.
module tb_data_memory_controller;

    localparam int TO = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        req_in = 1'b0;
    logic        write_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [1:0]  size_in = '0;
    logic        signed_in = 1'b0;
    logic [31:0] wdata_in = '0;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  error_out;
    logic [31:0] rdata_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [3:0]  mem_be_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ack_in = 1'b0;
    logic [31:0] mem_rdata_in = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;

    always #5 clk_in = ~clk_in;

    data_memory_controller #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req_in        (req_in),
        .write_in      (write_in),
        .addr_in       (addr_in),
        .size_in       (size_in),
        .signed_in     (signed_in),
        .wdata_in      (wdata_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .error_out     (error_out),
        .rdata_out     (rdata_out),
        .mem_req_out   (mem_req_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_be_out    (mem_be_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_ack_in    (mem_ack_in),
        .mem_rdata_in  (mem_rdata_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access from IDLE at a negedge; ack_delay = number of ACCESS cycles before the ack cycle
    task automatic run_access(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                              input logic [31:0] word, input int ack_delay);
        int          k;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] steer;
        logic [31:0] sh;
        logic [31:0] ld;
        int          exp_cycles;
        int          cycles;
        logic        got_done;

        k     = int'(addr[1:0]);
        mis   = (size == 2'b00) ? 1'b0 : (size == 2'b01) ? addr[0] : (addr[1:0] != 2'b00);
        be    = (size == 2'b00) ? 4'(1 << k) : (size == 2'b01) ? 4'(3 << k) : 4'hF;
        steer = wd << (8 * k);
        sh    = word >> (8 * k);
        if (size == 2'b00) begin
            ld = sh & 32'h0000_00FF;
            if (sgn && sh[7]) ld = ld | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            ld = sh & 32'h0000_FFFF;
            if (sgn && sh[15]) ld = ld | 32'hFFFF_0000;
        end else begin
            ld = word;
        end

        req_in = 1'b1; write_in = wr; addr_in = addr; size_in = size;
        signed_in = sgn; wdata_in = wd;
        @(negedge clk_in);
        req_in = 1'b0; write_in = $urandom; addr_in = $urandom; wdata_in = $urandom;
        size_in = 2'($urandom); signed_in = $urandom;

        if (mis) begin
            exp_err = 2'b01;
            check({tag, " mis done"}, 32'(done_out), 32'd1);
            check({tag, " mis req"}, 32'(mem_req_out), 32'd0);
            check({tag, " mis err"}, 32'(error_out), 32'(exp_err));
            check({tag, " mis rdata"}, rdata_out, exp_rdata);
        end else begin
            exp_cycles = (ack_delay < TO) ? ack_delay + 1 : TO;
            cycles   = 0;
            got_done = 1'b0;
            while (!got_done && cycles < 20) begin
                if (done_out) begin
                    got_done = 1'b1;
                end else begin
                    check({tag, " req"}, 32'(mem_req_out), 32'd1);
                    check({tag, " we"}, 32'(mem_we_out), 32'(wr));
                    check({tag, " addr"}, mem_addr_out, {addr[31:2], 2'b00});
                    check({tag, " be"}, 32'(mem_be_out), 32'(be));
                    if (wr) check({tag, " wdata"}, mem_wdata_out, steer);
                    mem_ack_in   = (cycles == ack_delay);
                    mem_rdata_in = mem_ack_in ? word : $urandom;
                    cycles++;
                    @(negedge clk_in);
                    mem_ack_in = 1'b0;
                end
            end
            check({tag, " done seen"}, 32'(got_done), 32'd1);
            check({tag, " cycles"}, 32'(cycles), 32'(exp_cycles));
            if (ack_delay < TO) begin
                exp_err = 2'b00;
                if (!wr) exp_rdata = ld;
            end else begin
                exp_err = 2'b10;
            end
            check({tag, " err"}, 32'(error_out), 32'(exp_err));
            check({tag, " rdata"}, rdata_out, exp_rdata);
        end

        @(negedge clk_in);
        check({tag, " done pulse"}, 32'(done_out), 32'd0);
        check({tag, " idle"}, 32'(busy_out), 32'd0);
        check({tag, " err held"}, 32'(error_out), 32'(exp_err));
    endtask

    initial begin
        exp_rdata = '0;
        exp_err   = 2'b00;

        #1;
        check("rst busy", 32'(busy_out), 32'd0);
        check("rst done", 32'(done_out), 32'd0);
        check("rst req", 32'(mem_req_out), 32'd0);
        check("rst we", 32'(mem_we_out), 32'd0);
        check("rst err", 32'(error_out), 32'd0);
        check("rst rdata", rdata_out, 32'd0);
        check("rst addr", mem_addr_out, 32'd0);
        check("rst be", 32'(mem_be_out), 32'd0);
        check("rst wdata", mem_wdata_out, 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        run_access("sbyte",  1'b0, 32'h0000_1003, 2'b00, 1'b1, 32'h0, 32'h8012_3456, 2);
        run_access("uhalf",  1'b0, 32'h0000_2002, 2'b01, 1'b0, 32'h0, 32'hBEEF_0000, 1);
        run_access("bstore", 1'b1, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 3);
        run_access("misw",   1'b0, 32'h0000_0006, 2'b11, 1'b0, 32'h0, 32'h1234_5678, 0);
        run_access("tmo",    1'b0, 32'h0000_0040, 2'b11, 1'b0, 32'h0, 32'hDEAD_BEEF, 99);
        run_access("ackto",  1'b0, 32'h0000_0044, 2'b11, 1'b0, 32'h0, 32'hCAFE_F00D, TO - 1);
        run_access("zwait",  1'b0, 32'h0000_0048, 2'b10, 1'b1, 32'h0, 32'h8000_0001, 0);

        // Stray ack while idle must not start or finish anything
        mem_ack_in = 1'b1;
        @(negedge clk_in);
        mem_ack_in = 1'b0;
        check("idle ack done", 32'(done_out), 32'd0);
        check("idle ack busy", 32'(busy_out), 32'd0);

        // Reset in the middle of ACCESS
        req_in = 1'b1; write_in = 1'b1; addr_in = 32'h0000_0100; size_in = 2'b11;
        wdata_in = 32'h1122_3344;
        @(negedge clk_in);
        req_in = 1'b0;
        @(negedge clk_in);
        check("pre-rst req", 32'(mem_req_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check("rst req drop", 32'(mem_req_out), 32'd0);
        check("rst busy drop", 32'(busy_out), 32'd0);
        check("rst no done", 32'(done_out), 32'd0);
        @(negedge clk_in);
        check("rst still no done", 32'(done_out), 32'd0);
        rst_n_in  = 1'b1;
        exp_rdata = '0;
        exp_err   = 2'b00;
        check("post-rst rdata", rdata_out, exp_rdata);
        run_access("post-rst", 1'b0, 32'h0000_0200, 2'b01, 1'b1, 32'h0, 32'h0000_9ABC, 1);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) a[1:0] = (sz == 2'b00) ? a[1:0] : (sz == 2'b01) ? {a[1], 1'b0} : 2'b00;
            run_access($sformatf("rnd%0d", i), 1'($urandom), a, sz, 1'($urandom),
                       $urandom, $urandom, $urandom_range(0, 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
